// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ahb_pkg                                                     |
// | Brief  : Shared AHB-Lite types and arbiter state/master encodings.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      SIZE_BYTE  = 2'b00,
      SIZE_HALF  = 2'b01,
      SIZE_WORD  = 2'b10,
      SIZE_DWORD = 2'b11
   } hsize_t;

   typedef enum logic [1:0] {
      PARK  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } arb_state_t;

   localparam logic MST_A = 1'b0;
   localparam logic MST_B = 1'b1;

   function automatic logic is_active(htrans_t t);
      return (t == NONSEQ) || (t == SEQ);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_arbiter_2m_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ahb_arbiter_2m_if                                           |
// | Brief  : Two-master request/address bus plus shared slave-side bus.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface ahb_arbiter_2m_if;
   import ahb_pkg::*;

   logic        HBUSREQ_A, HBUSREQ_B;
   logic        HLOCK_A, HLOCK_B;
   htrans_t     HTRANS_A, HTRANS_B;
   logic [31:0] HADDR_A, HADDR_B;
   logic        HWRITE_A, HWRITE_B;
   hsize_t      HSIZE_A, HSIZE_B;
   logic [31:0] HWDATA_A, HWDATA_B;
   logic        HREADY;

   logic        HGRANT_A, HGRANT_B;
   logic        HMASTER;
   logic        HMASTLOCK;
   logic [31:0] HADDR;
   htrans_t     HTRANS;
   logic        HWRITE;
   hsize_t      HSIZE;
   logic [31:0] HWDATA;
   logic        arbiter_WR;

   // Arbiter-side view.
   modport slave (
      input  HBUSREQ_A, HBUSREQ_B, HLOCK_A, HLOCK_B, HTRANS_A, HTRANS_B,
             HADDR_A, HADDR_B, HWRITE_A, HWRITE_B, HSIZE_A, HSIZE_B,
             HWDATA_A, HWDATA_B, HREADY,
      output HGRANT_A, HGRANT_B, HMASTER, HMASTLOCK, HADDR, HTRANS,
             HWRITE, HSIZE, HWDATA, arbiter_WR
   );

   // Master/environment-side view.
   modport master (
      output HBUSREQ_A, HBUSREQ_B, HLOCK_A, HLOCK_B, HTRANS_A, HTRANS_B,
             HADDR_A, HADDR_B, HWRITE_A, HWRITE_B, HSIZE_A, HSIZE_B,
             HWDATA_A, HWDATA_B, HREADY,
      input  HGRANT_A, HGRANT_B, HMASTER, HMASTLOCK, HADDR, HTRANS,
             HWRITE, HSIZE, HWDATA, arbiter_WR
   );

endinterface
`default_nettype wire

// File: rtl/ahb_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ahb_arb_pick                                                |
// | Brief  : Combinational two-way winner select (fixed or round-robin). |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ahb_arb_pick
   import ahb_pkg::*;
#(
   parameter int ROUND_ROBIN = 1
) (
   input  logic req_a,
   input  logic req_b,
   input  logic last_owner,
   output logic winner,
   output logic valid
);

   always_comb begin
      valid  = req_a | req_b;
      winner = MST_A;
      if (req_a && req_b) begin
         winner = (ROUND_ROBIN != 0) ? ~last_owner : MST_A;
      end else if (req_b) begin
         winner = MST_B;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ahb_arbiter_2m.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ahb_arbiter_2m                                              |
// | Brief  : Two-master AHB-Lite arbiter with address/write-data mux.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ahb_arbiter_2m
   import ahb_pkg::*;
#(
   parameter int ROUND_ROBIN = 1,
   parameter int MAX_BURST   = 16,
   parameter int DEF_MASTER  = 0
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   ahb_arbiter_2m_if.slave  bus
);

   localparam int               CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
   localparam logic             DEF_ID  = (DEF_MASTER != 0);

   arb_state_t       state, state_next;
   logic             last_owner, last_next;
   logic             hmaster, data_owner, hmastlock, arb_wr;
   logic [CNT_W-1:0] beat_cnt;
   logic             grant_a, grant_b, granted;
   logic             own_req, own_lock, other_req, settled, rearb;
   htrans_t          own_trans;
   logic             win, win_valid;

   ahb_arb_pick #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
      .req_a      (bus.HBUSREQ_A),
      .req_b      (bus.HBUSREQ_B),
      .last_owner (last_owner),
      .winner     (win),
      .valid      (win_valid)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= PARK;
         last_owner <= MST_A;
      end else if (bus.HREADY) begin
         state      <= state_next;
         last_owner <= last_next;
      end
   end

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      case (state)
         GNT_A:   grant_a = 1'b1;
         GNT_B:   grant_b = 1'b1;
         default: begin
            grant_a = (DEF_ID == MST_A);
            grant_b = (DEF_ID == MST_B);
         end
      endcase
      granted   = grant_b;
      own_req   = granted ? bus.HBUSREQ_B : bus.HBUSREQ_A;
      own_lock  = granted ? bus.HLOCK_B   : bus.HLOCK_A;
      own_trans = granted ? bus.HTRANS_B  : bus.HTRANS_A;
      other_req = granted ? bus.HBUSREQ_A : bus.HBUSREQ_B;
      // IDLE and burst-limit only count once the grantee owns the address
      // phase; before that its HTRANS is not on the bus and the counter
      // still reflects the previous owner.
      settled   = (hmaster == granted);

      if (state == PARK) begin
         rearb = 1'b1;
      end else if (own_lock) begin
         rearb = (own_trans == IDLE) && !own_req;
      end else begin
         rearb = !own_req ||
                 (settled && ((own_trans == IDLE) ||
                              ((beat_cnt == MAX_CNT) && other_req)));
      end

      state_next = state;
      last_next  = last_owner;
      if (rearb) begin
         if (win_valid) begin
            state_next = win ? GNT_B : GNT_A;
            last_next  = win;
         end else begin
            state_next = PARK;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hmaster    <= DEF_ID;
         data_owner <= DEF_ID;
         hmastlock  <= 1'b0;
         arb_wr     <= 1'b0;
         beat_cnt   <= '0;
      end else if (bus.HREADY) begin
         hmaster    <= granted;
         data_owner <= hmaster;
         hmastlock  <= own_lock;
         arb_wr     <= bus.HWRITE && is_active(bus.HTRANS);
         if (granted != hmaster) begin
            beat_cnt <= '0;
         end else if (is_active(bus.HTRANS) && (beat_cnt != MAX_CNT)) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   assign bus.HGRANT_A   = grant_a;
   assign bus.HGRANT_B   = grant_b;
   assign bus.HMASTER    = hmaster;
   assign bus.HMASTLOCK  = hmastlock;
   assign bus.arbiter_WR = arb_wr;
   assign bus.HADDR      = hmaster ? bus.HADDR_B  : bus.HADDR_A;
   assign bus.HTRANS     = hmaster ? bus.HTRANS_B : bus.HTRANS_A;
   assign bus.HWRITE     = hmaster ? bus.HWRITE_B : bus.HWRITE_A;
   assign bus.HSIZE      = hmaster ? bus.HSIZE_B  : bus.HSIZE_A;
   assign bus.HWDATA     = data_owner ? bus.HWDATA_B : bus.HWDATA_A;

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter_2m.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_ahb_arbiter_2m                                           |
// | Brief  : Directed vector bench for the two-master AHB arbiter.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_ahb_arbiter_2m;
   import ahb_pkg::*;

   localparam logic [31:0] ADDR_A = 32'hA000_0040;
   localparam logic [31:0] ADDR_B = 32'h0000_0010;
   localparam logic [31:0] DATA_A = 32'hAAAA_5555;
   localparam logic [31:0] DATA_B = 32'hBBBB_3333;

   logic HCLK = 1'b0;
   logic HRESETn;
   int   checks   = 0;
   int   failures = 0;

   ahb_arbiter_2m_if bus ();

   ahb_arbiter_2m #(
      .ROUND_ROBIN (1),
      .MAX_BURST   (4),
      .DEF_MASTER  (0)
   ) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic    ra, rb, la, wa, wb, rdy;
      htrans_t ta, tb;
      logic    ega, egb, ehm, edo, ewr, elk;
      bit      ccnt;
      int      ecnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic ra, input logic rb, input logic la,
      input htrans_t ta, input htrans_t tb,
      input logic wa, input logic wb, input logic rdy,
      input logic ega, input logic egb, input logic ehm,
      input logic edo, input logic ewr, input logic elk,
      input bit ccnt = 1'b0, input int ecnt = 0);
      vec_t v;
      v.ra = ra;  v.rb = rb;  v.la = la;  v.ta = ta;  v.tb = tb;
      v.wa = wa;  v.wb = wb;  v.rdy = rdy;
      v.ega = ega; v.egb = egb; v.ehm = ehm; v.edo = edo;
      v.ewr = ewr; v.elk = elk; v.ccnt = ccnt; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.HBUSREQ_A = v.ra;
      bus.HBUSREQ_B = v.rb;
      bus.HLOCK_A   = v.la;
      bus.HLOCK_B   = 1'b0;
      bus.HTRANS_A  = v.ta;
      bus.HTRANS_B  = v.tb;
      bus.HWRITE_A  = v.wa;
      bus.HWRITE_B  = v.wb;
      bus.HREADY    = v.rdy;
   endtask

   task automatic expect_outs(input string tag, input vec_t v);
      check({tag, ".grant_a"},  32'(bus.HGRANT_A),  32'(v.ega));
      check({tag, ".grant_b"},  32'(bus.HGRANT_B),  32'(v.egb));
      check({tag, ".hmaster"},  32'(bus.HMASTER),   32'(v.ehm));
      check({tag, ".mastlock"}, 32'(bus.HMASTLOCK), 32'(v.elk));
      check({tag, ".arb_wr"},   32'(bus.arbiter_WR), 32'(v.ewr));
      check({tag, ".haddr"},    bus.HADDR, v.ehm ? ADDR_B : ADDR_A);
      check({tag, ".htrans"},   32'(bus.HTRANS), 32'(v.ehm ? v.tb : v.ta));
      check({tag, ".hwdata"},   bus.HWDATA, v.edo ? DATA_B : DATA_A);
      if (v.ccnt) check({tag, ".beat_cnt"}, 32'(dut.beat_cnt), 32'(v.ecnt));
   endtask

   task automatic apply(input string tag, input vec_t v);
      drive(v);
      @(negedge HCLK);
      expect_outs(tag, v);
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      bus.HADDR_A  = ADDR_A;
      bus.HADDR_B  = ADDR_B;
      bus.HWDATA_A = DATA_A;
      bus.HWDATA_B = DATA_B;
      bus.HSIZE_A  = SIZE_WORD;
      bus.HSIZE_B  = SIZE_WORD;
      HRESETn = 1'b0;
      drive(mk(0,0,0,IDLE,IDLE,0,0,1, 1,0,0,0,0,0));
      @(negedge HCLK);
      check("in_reset.grant_a", 32'(bus.HGRANT_A), 32'd1);
      check("in_reset.hmaster", 32'(bus.HMASTER), 32'd0);
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;

      // B takes the bus, then releases it back to park.
      vecs.push_back(mk(0,0,0,IDLE,IDLE,  0,0,1, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,IDLE,IDLE,  0,0,1, 1,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,IDLE,NONSEQ,0,1,1, 0,1,0,0,0,0));
      vecs.push_back(mk(0,1,0,IDLE,NONSEQ,0,1,1, 0,1,1,0,0,0));
      vecs.push_back(mk(0,0,0,IDLE,IDLE,  0,0,1, 0,1,1,1,1,0));
      vecs.push_back(mk(0,0,0,IDLE,IDLE,  0,0,1, 1,0,1,1,0,0));
      vecs.push_back(mk(0,0,0,IDLE,IDLE,  0,0,1, 1,0,0,1,0,0));
      vecs.push_back(mk(0,0,0,IDLE,IDLE,  0,0,1, 1,0,0,0,0,0));
      // Contention: A bursts, preempted after 4 counted beats.
      vecs.push_back(mk(1,0,0,IDLE,IDLE,  0,0,1, 1,0,0,0,0,0));
      vecs.push_back(mk(1,1,0,NONSEQ,IDLE,1,0,1, 1,0,0,0,0,0, 1,0));
      vecs.push_back(mk(1,1,0,SEQ,IDLE,   1,0,1, 1,0,0,0,1,0));
      vecs.push_back(mk(1,1,0,SEQ,IDLE,   1,0,1, 1,0,0,0,1,0));
      vecs.push_back(mk(1,1,0,SEQ,IDLE,   1,0,1, 1,0,0,0,1,0));
      vecs.push_back(mk(1,1,0,SEQ,IDLE,   1,0,1, 1,0,0,0,1,0, 1,4));
      vecs.push_back(mk(1,1,0,SEQ,NONSEQ, 1,1,1, 0,1,0,0,1,0, 1,4));
      vecs.push_back(mk(1,1,0,IDLE,NONSEQ,0,1,1, 0,1,1,0,1,0, 1,0));
      vecs.push_back(mk(1,0,0,IDLE,IDLE,  0,0,1, 0,1,1,1,1,0));
      vecs.push_back(mk(0,0,0,IDLE,IDLE,  0,0,1, 1,0,1,1,0,0));
      vecs.push_back(mk(0,0,0,IDLE,IDLE,  0,0,1, 1,0,0,1,0,0));
      vecs.push_back(mk(0,0,0,IDLE,IDLE,  0,0,1, 1,0,0,0,0,0));

      foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

      // Handover stalled by three wait states.
      apply("ws0", mk(1,0,0,IDLE,IDLE,  0,0,1, 1,0,0,0,0,0));
      apply("ws1", mk(1,0,0,NONSEQ,IDLE,1,0,1, 1,0,0,0,0,0));
      apply("ws2", mk(0,1,0,NONSEQ,IDLE,1,0,1, 1,0,0,0,1,0));
      for (int i = 0; i < 3; i++)
         apply($sformatf("ws_hold%0d", i),
               mk(0,1,0,IDLE,NONSEQ,0,1,0, 0,1,0,0,1,0));
      apply("ws6", mk(0,1,0,IDLE,NONSEQ,0,1,1, 0,1,0,0,1,0));
      apply("ws7", mk(0,1,0,IDLE,NONSEQ,0,1,1, 0,1,1,0,0,0, 1,0));

      // Asynchronous reset while B owns the bus and HREADY is low.
      drive(mk(0,1,0,IDLE,SEQ,0,1,0, 0,1,1,1,1,0));
      @(negedge HCLK);
      check("pre_rst.grant_b", 32'(bus.HGRANT_B), 32'd1);
      check("pre_rst.hmaster", 32'(bus.HMASTER), 32'd1);
      check("pre_rst.arb_wr",  32'(bus.arbiter_WR), 32'd1);
      check("pre_rst.hwdata",  bus.HWDATA, DATA_B);
      #2 HRESETn = 1'b0;
      #1;
      check("async_rst.grant_a",  32'(bus.HGRANT_A), 32'd1);
      check("async_rst.grant_b",  32'(bus.HGRANT_B), 32'd0);
      check("async_rst.hmaster",  32'(bus.HMASTER), 32'd0);
      check("async_rst.arb_wr",   32'(bus.arbiter_WR), 32'd0);
      check("async_rst.mastlock", 32'(bus.HMASTLOCK), 32'd0);
      check("async_rst.haddr",    bus.HADDR, ADDR_A);
      check("async_rst.hwdata",   bus.HWDATA, DATA_A);
      check("async_rst.beat_cnt", 32'(dut.beat_cnt), 32'd0);
      drive(mk(0,0,0,IDLE,IDLE,0,0,1, 1,0,0,0,0,0));
      @(posedge HCLK);
      #1 HRESETn = 1'b1;

      // Locked 20-beat burst by A with B requesting throughout.
      apply("lk0", mk(1,0,1,IDLE,IDLE,0,0,1, 1,0,0,0,0,0));
      for (int i = 1; i <= 20; i++)
         apply($sformatf("lk%0d", i),
               mk(1,1,1,(i == 1) ? NONSEQ : SEQ,IDLE,1,0,1,
                  1,0,0,0,(i >= 2),1));
      apply("lk21", mk(1,1,1,IDLE,IDLE,  0,0,1, 1,0,0,0,1,1));
      apply("lk22", mk(0,1,1,IDLE,IDLE,  0,0,1, 1,0,0,0,0,1));
      apply("lk23", mk(0,1,0,IDLE,NONSEQ,0,1,1, 0,1,0,0,0,1));
      apply("lk24", mk(0,1,0,IDLE,NONSEQ,0,1,1, 0,1,1,0,0,0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ahb_arbiter_2m.md
Name: ahb_arbiter_2m

Overview:
- Two-master AHB-Lite bus arbiter and address/write-data multiplexer. It sits between masters A and B and the shared slave interface (HSEL_P/HREADY_P path).
- Grants bus ownership and tracks the address-phase owner (HMASTER) and the data-phase owner.
- Drives the shared HADDR/HTRANS/HWRITE/HSIZE/HWDATA and the arbiter_WR write qualifier consumed by the slave interface.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate on contention; 0 = fixed priority, A wins.
- MAX_BURST, 16: accepted beats an unlocked owner may hold while the other master requests.
- DEF_MASTER, 0: parked master when nobody requests (0 = A, 1 = B).

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- HBUSREQ_A / HBUSREQ_B  in  1  bus request
- HLOCK_A / HLOCK_B  in  1  locked-transfer request
- HTRANS_A / HTRANS_B  in  2  master transfer type
- HADDR_A / HADDR_B  in  32  master address
- HWRITE_A / HWRITE_B  in  1  master write
- HSIZE_A / HSIZE_B  in  2  master size
- HWDATA_A / HWDATA_B  in  32  master write data
- HREADY  in  1  combined slave ready (HREADY_P)
- HGRANT_A / HGRANT_B  out  1  grant, one-hot
- HMASTER  out  1  address-phase owner (0 = A, 1 = B)
- HMASTLOCK  out  1  owner's transfer is locked
- HADDR  out  32  muxed address
- HTRANS  out  2  muxed transfer type
- HWRITE  out  1  muxed write
- HSIZE  out  2  muxed size
- HWDATA  out  32  write data, muxed by data-phase owner
- arbiter_WR  out  1  current data phase is a valid write

Behaviour:
- Reset (asynchronous, any cycle, including mid-burst):
  - HGRANT = DEF_MASTER one-hot; HMASTER = DEF_MASTER; data owner = DEF_MASTER.
  - HMASTLOCK = 0, arbiter_WR = 0, beat counter = 0, RR pointer = A.
  - FSM = PARK.
- FSM states:
  - PARK: default master granted, no requests.
  - GNT_A, GNT_B.
  - All state and grant registers update only on edges where HREADY = 1. With HREADY = 0, grants are frozen.
- Re-arbitration is allowed at an HREADY = 1 edge when either:
  - the owner's HLOCK is 0 and any of: owner HBUSREQ = 0, owner HTRANS = IDLE, or beat count = MAX_BURST while the other master requests; or
  - the owner has HLOCK = 1 and HTRANS = IDLE with HBUSREQ = 0.
- Winner selection:
  - Only one requester: that master wins.
  - Both request: ROUND_ROBIN = 1 gives the master that was not the last owner; ROUND_ROBIN = 0 gives A.
  - None request: go to PARK.
- Latency:
  - HGRANT changes one edge after the deciding cycle.
  - HMASTER <= granted master on the next HREADY = 1 edge.
  - Data owner <= HMASTER on each HREADY = 1 edge.
- Beat counter:
  - Increments on HREADY = 1 when muxed HTRANS is NONSEQ or SEQ.
  - Saturates at MAX_BURST.
  - Clears on every HMASTER change.
- Address/control mux (HADDR/HTRANS/HWRITE/HSIZE): combinational select on HMASTER.
- HWDATA mux: combinational select on the data owner.
- HMASTLOCK = registered (HLOCK of granted master), updated together with HMASTER.
- arbiter_WR:
  - Registered on HREADY = 1 as (HWRITE & HTRANS in NONSEQ/SEQ) of the address phase.
  - Holds its value while HREADY = 0.
- Invariants:
  - HGRANT_A & HGRANT_B is never 1.
  - Exactly one grant is asserted every cycle after reset.

Decomposition:
- Shared package ahb_pkg:
  - htrans_t enum (IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11), also used by the slave interface.
  - hsize_t.
  - arb_state_t {PARK, GNT_A, GNT_B}.
  - Master ID constants MST_A = 0, MST_B = 1.
- One sub-module, ahb_arb_pick: combinational winner selection (requests, last owner, ROUND_ROBIN) -> winner, valid.
- FSM, counters and muxes stay in the top.

Test Plan:
- Reset, no requests:
  - Stimulus: release HRESETn with HBUSREQ_A = HBUSREQ_B = 0.
  - Response: HGRANT_A = 1, HMASTER = 0, HTRANS = HTRANS_A = IDLE, arbiter_WR = 0.
- Master B takes the bus:
  - Stimulus: HBUSREQ_B = 1 only, HREADY = 1.
  - Response: HGRANT_B = 1 one edge later. HMASTER = 1 on the following edge. B's NONSEQ write to 0x0000_0010 appears on HADDR. arbiter_WR = 1 and HWDATA = HWDATA_B in the next cycle.
- Contention with ROUND_ROBIN = 1, MAX_BURST = 4:
  - Stimulus: both masters request; A issues a SEQ burst of 8.
  - Response: A keeps ownership for 4 accepted beats, then HGRANT_B = 1. The counter returns to 0 after the handover.
- Wait states:
  - Stimulus: HREADY = 0 for 3 cycles during a handover.
  - Response: HGRANT, HMASTER, data owner and arbiter_WR are all held. Handover completes at the first HREADY = 1 edge.
- Locked transfer:
  - Stimulus: HLOCK_A = 1 through a 20-beat burst while B requests.
  - Response: no grant change, HMASTLOCK = 1. B is granted only after A drives IDLE with HBUSREQ_A = 0.
- Reset mid-burst:
  - Stimulus: assert HRESETn = 0 asynchronously while B owns the bus with HREADY = 0.
  - Response: all outputs return to reset values immediately, without waiting for a clock edge.
